// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bi subtractor with start/busy/done handshake
module serial_subtractor #(
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [B-1:0] a,
    input  logic [B-1:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [B-1:0] di,
    output logic         bo
);

    localparam int CW = $clog2(B + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [B-1:0]  a_sr;
    logic [B-1:0]  b_sr;
    logic [B-1:0]  res_sr;
    logic [B-1:0]  res_shift;
    logic          br;
    logic          br_next;
    logic          d_bit;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last_step;

    // One full-subtractor cell on the operand LSBs plus the result shifted with the new bit at its MSB.
    always_comb begin
        accept    = start && (state != SHIFT);
        last_step = (state == SHIFT) && (cnt == CW'(B - 1));
        d_bit     = a_sr[0] ^ b_sr[0] ^ br;
        br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        res_shift        = res_sr >> 1;
        res_shift[B-1]   = d_bit;
    end

    // Next-state and handshake outputs; start is ignored while shifting.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, serial step and result publication; di/bo only move on the final step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            di     <= '0;
            bo     <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= bi;
            cnt    <= '0;
            res_sr <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br     <= br_next;
            res_sr <= res_shift;
            cnt    <= cnt + CW'(1);
            if (last_step) begin
                di <= res_shift;
                bo <= br_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at B=8 and B=1
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, bi8, busy8, done8, bo8;
    logic [7:0] a8, b8, di8;
    logic       start1, bi1, busy1, done1, bo1;
    logic [0:0] a1, b1, di1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
    } op_t;

    serial_subtractor #(.B(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bi(bi8),
        .busy(busy8), .done(done8), .di(di8), .bo(bo8)
    );

    serial_subtractor #(.B(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bi(bi1),
        .busy(busy1), .done(done1), .di(di1), .bo(bo1)
    );

    always #5 clk = ~clk;

    // Starts one B=8 operation and waits (bounded) for done; operands are scrambled after accept.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi_v,
                        output int busy_cycles, output bit got_done,
                        output logic [7:0] d, output logic o);
        d = 'x;
        o = 'x;
        @(negedge clk);
        a8 = a; b8 = b; bi8 = bi_v; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        busy_cycles = 0;
        got_done = 0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (done8) begin
                got_done = 1;
                d = di8;
                o = bo8;
            end else begin
                if (busy8) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run1(input logic a, input logic b, input logic bi_v,
                        output int busy_cycles, output bit got_done,
                        output logic d, output logic o);
        d = 'x;
        o = 'x;
        @(negedge clk);
        a1 = a; b1 = b; bi1 = bi_v; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom);
        busy_cycles = 0;
        got_done = 0;
        for (int i = 0; i < 10 && !got_done; i++) begin
            if (done1) begin
                got_done = 1;
                d = di1[0];
                o = bo1;
            end else begin
                if (busy1) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 0; a8 = 8'hA5; b8 = 8'h5A; bi8 = 1;
        start1 = 0; a1 = 1'b1; b1 = 1'b0; bi1 = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, di8, bo8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b di=%h bo=%b, want all 0", busy8, done8, di8, bo8);
        end
        checks++;
        if ({busy1, done1, di1, bo1} !== 4'd0) begin
            errors++;
            $display("FAIL reset1: busy=%b done=%b di=%b bo=%b, want all 0", busy1, done1, di1, bo1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        op_t        vec[4];
        logic [7:0] exp_di[4];
        logic       exp_bo[4];
        int         bc;
        bit         gd;
        logic [7:0] d;
        logic       o;
        vec[0] = '{8'hCC, 8'h0F, 1'b0}; exp_di[0] = 8'hBD; exp_bo[0] = 1'b0;
        vec[1] = '{8'h0F, 8'hCC, 1'b0}; exp_di[1] = 8'h43; exp_bo[1] = 1'b1;
        vec[2] = '{8'h00, 8'h00, 1'b1}; exp_di[2] = 8'hFF; exp_bo[2] = 1'b1;
        vec[3] = '{8'h80, 8'h7F, 1'b1}; exp_di[3] = 8'h00; exp_bo[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run8(vec[i].a, vec[i].b, vec[i].bi, bc, gd, d, o);
            checks++;
            if (bc != 8 || !gd) begin
                errors++;
                $display("FAIL vec%0d_timing: busy_cycles=%0d done=%0d, want 8 and 1", i, bc, gd);
            end
            checks++;
            if (d !== exp_di[i] || o !== exp_bo[i]) begin
                errors++;
                $display("FAIL vec%0d_result: di=%h bo=%b, want di=%h bo=%b", i, d, o, exp_di[i], exp_bo[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || di8 !== 8'h00 || bo8 !== 1'b0) begin
            errors++;
            $display("FAIL hold_after_done: done=%b busy=%b di=%h bo=%b, want 0 0 00 0", done8, busy8, di8, bo8);
        end
    endtask

    task automatic test_back_to_back();
        op_t q[$];
        op_t op;
        op_t exp_op;
        int  since = 0;
        int  ndone = 0;
        int  overlap = 0;
        int  diff;
        logic [7:0] exp_di;
        logic       exp_bo;
        @(negedge clk);
        op = '{8'($urandom), 8'($urandom), 1'($urandom)};
        a8 = op.a; b8 = op.b; bi8 = op.bi; start8 = 1'b1;
        q.push_back(op);
        for (int cyc = 0; cyc < 60 && ndone < 4; cyc++) begin
            @(negedge clk);
            since++;
            if (busy8 && done8) overlap++;
            op = '{8'($urandom), 8'($urandom), 1'($urandom)};
            a8 = op.a; b8 = op.b; bi8 = op.bi;
            if (done8) begin
                exp_op = q.pop_front();
                diff   = int'(exp_op.a) - int'(exp_op.b) - int'(exp_op.bi);
                exp_bo = diff < 0;
                exp_di = 8'((diff + 512) % 256);
                checks++;
                if (di8 !== exp_di || bo8 !== exp_bo) begin
                    errors++;
                    $display("FAIL b2b_result%0d: di=%h bo=%b, want di=%h bo=%b", ndone, di8, bo8, exp_di, exp_bo);
                end
                checks++;
                if (since != 9) begin
                    errors++;
                    $display("FAIL b2b_period%0d: %0d cycles between done pulses, want 9", ndone, since);
                end
                since = 0;
                ndone++;
                q.push_back(op);
            end
        end
        start8 = 1'b0;
        checks++;
        if (ndone != 4 || overlap != 0) begin
            errors++;
            $display("FAIL b2b_summary: done_count=%0d overlap=%0d, want 4 and 0", ndone, overlap);
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int         ndone = 0;
        int         bc;
        bit         gd;
        logic [7:0] d;
        logic       o;
        run8(8'hF0, 8'h0E, 1'b0, bc, gd, d, o);
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; bi8 = 0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b1 || di8 !== 8'hE2) begin
            errors++;
            $display("FAIL abort_pre: busy=%b di=%h, want busy=1 di=e2", busy8, di8);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy8, done8, di8, bo8} !== 11'd0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b di=%h bo=%b, want all 0", busy8, done8, di8, bo8);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles after abort, want 0", ndone);
        end
        run8(8'h10, 8'h01, 1'b0, bc, gd, d, o);
        checks++;
        if (!gd || bc != 8 || d !== 8'h0F || o !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: done=%0d busy_cycles=%0d di=%h bo=%b, want 1 8 0f 0", gd, bc, d, o);
        end
    endtask

    task automatic test_random8();
        int         bc;
        bit         gd;
        logic [7:0] d;
        logic       o;
        logic [7:0] ra, rb;
        logic       rbi;
        int         diff;
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
            if (i == 1) begin ra = 8'hFF; rb = 8'h00; rbi = 1'b0; end
            run8(ra, rb, rbi, bc, gd, d, o);
            diff = int'(ra) - int'(rb) - int'(rbi);
            checks++;
            if (!gd || bc != 8 || d !== 8'((diff + 512) % 256) || o !== (diff < 0)) begin
                errors++;
                $display("FAIL rand8_%0d: a=%h b=%h bi=%b -> done=%0d busy_cycles=%0d di=%h bo=%b, want 1 8 %h %b",
                         i, ra, rb, rbi, gd, bc, d, o, 8'((diff + 512) % 256), diff < 0);
            end
        end
    endtask

    task automatic test_random1();
        int   bc;
        bit   gd;
        logic d, o;
        logic ra, rb, rbi;
        int   diff;
        for (int i = 0; i < 16; i++) begin
            ra = 1'($urandom); rb = 1'($urandom); rbi = 1'($urandom);
            if (i < 8) {ra, rb, rbi} = 3'(i);
            run1(ra, rb, rbi, bc, gd, d, o);
            diff = int'(ra) - int'(rb) - int'(rbi);
            checks++;
            if (!gd || bc != 1 || d !== 1'((diff + 4) % 2) || o !== (diff < 0)) begin
                errors++;
                $display("FAIL rand1_%0d: a=%b b=%b bi=%b -> done=%0d busy_cycles=%0d di=%b bo=%b, want 1 1 %b %b",
                         i, ra, rb, rbi, gd, bc, d, o, 1'((diff + 4) % 2), diff < 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        test_random8();
        test_random1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
